// File: rtl/game_world_fsm.sv
// Game-side world model: IDLE/RUN/CRASHED state machine, two obstacle slots with
// LFSR-driven spawning, player jump arc and collision. Everything advances on game_tick.
module game_world_fsm #(
   parameter int CONV          = 0,
   parameter int GEN_LINE      = 250,
   parameter int PLAYER_OFFSET = 6,
   parameter int OBST_SPEED    = 2,
   parameter int MIN_GAP       = 60,
   parameter int JUMP_HALF     = 12,
   parameter int JUMP_STEP     = 4,
   parameter int CLEAR_Y       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             game_tick,
   input  logic             button_start,
   input  logic             button_up,
   input  logic             button_down,
   output logic [9-CONV:0]  obstacle1_pos,
   output logic [9-CONV:0]  obstacle2_pos,
   output logic [7:0]       player_y,
   output logic             player_ducking,
   output logic             crash,
   output logic             game_frozen,
   output logic [15:0]      score
);

   localparam int PW = 10 - CONV;
   localparam int CW = $clog2(2 * JUMP_HALF + 1);

   localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] POS_GEN   = PW'(GEN_LINE);
   localparam logic [PW-1:0] POS_GAP   = PW'(GEN_LINE - MIN_GAP);
   localparam logic [PW-1:0] POS_SPD   = PW'(OBST_SPEED);
   localparam logic [PW-1:0] POS_OFF   = PW'(PLAYER_OFFSET);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_HALF  = CW'(JUMP_HALF);
   localparam logic [CW-1:0] CNT_FULL  = CW'(2 * JUMP_HALF);
   localparam logic [7:0]    Y_STEP    = 8'(JUMP_STEP);
   localparam logic [7:0]    Y_CLEAR   = 8'(CLEAR_Y);
   localparam logic [7:0]    LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CRASHED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pos1_q, pos1_d;
   logic [PW-1:0] pos2_q, pos2_d;
   logic [7:0]    y_q, y_d;
   logic [CW-1:0] jc_q, jc_d;
   logic [15:0]   score_q, score_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic          duck_q, duck_d;
   logic          crash_q, crash_d;
   logic          frozen_q, frozen_d;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      lfsr_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [PW-1:0] scroll(input logic [PW-1:0] p);
      if (p <= POS_SPD) begin
         scroll = POS_ZERO;
      end else begin
         scroll = p - POS_SPD;
      end
   endfunction

   function automatic logic hit(input logic [PW-1:0] p);
      hit = (p != POS_ZERO) && (p <= POS_OFF);
   endfunction

   // Next-state and next-output computation for one game tick
   always_comb begin
      state_d  = state_q;
      pos1_d   = pos1_q;
      pos2_d   = pos2_q;
      y_d      = y_q;
      jc_d     = jc_q;
      score_d  = score_q;
      lfsr_d   = lfsr_q;
      duck_d   = duck_q;
      crash_d  = crash_q;
      frozen_d = frozen_q;
      if (game_tick) begin
         case (state_q)
            ST_RUN: begin
               score_d = score_q + 16'd1;
               lfsr_d  = lfsr_step(lfsr_q);
               pos1_d  = scroll(pos1_q);
               pos2_d  = scroll(pos2_q);
               // Eligibility uses pre-tick slots, so a slot freed this tick stays empty one more tick.
               if (lfsr_q[1:0] == 2'b00) begin
                  if (pos1_q == POS_ZERO) begin
                     if ((pos2_q == POS_ZERO) || (pos2_q < POS_GAP)) begin
                        pos1_d = POS_GEN;
                     end else begin
                        pos1_d = POS_ZERO;
                     end
                  end else if (pos2_q == POS_ZERO) begin
                     if (pos1_q < POS_GAP) begin
                        pos2_d = POS_GEN;
                     end else begin
                        pos2_d = POS_ZERO;
                     end
                  end else begin
                     pos1_d = scroll(pos1_q);
                  end
               end else begin
                  pos2_d = scroll(pos2_q);
               end

               duck_d = button_down & (y_q == 8'd0);
               if (jc_q == CNT_ZERO) begin
                  if (button_up && (y_q == 8'd0)) begin
                     jc_d = CNT_ONE;
                     y_d  = Y_STEP;
                  end else begin
                     jc_d = CNT_ZERO;
                     y_d  = y_q;
                  end
               end else if (jc_q < CNT_HALF) begin
                  y_d  = y_q + Y_STEP;
                  jc_d = jc_q + CNT_ONE;
               end else if (jc_q < CNT_FULL) begin
                  y_d  = y_q - Y_STEP;
                  jc_d = jc_q + CNT_ONE;
               end else begin
                  y_d  = 8'd0;
                  jc_d = CNT_ZERO;
               end

               if ((hit(pos1_d) || hit(pos2_d)) && (y_d < Y_CLEAR)) begin
                  state_d = ST_CRASHED;
                  crash_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  crash_d = 1'b0;
               end
            end
            ST_IDLE, ST_CRASHED: begin
               duck_d = 1'b0;
               if (button_start) begin
                  state_d  = ST_RUN;
                  pos1_d   = POS_ZERO;
                  pos2_d   = POS_ZERO;
                  y_d      = 8'd0;
                  jc_d     = CNT_ZERO;
                  score_d  = 16'd0;
                  crash_d  = 1'b0;
                  frozen_d = 1'b0;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               duck_d   = 1'b0;
               crash_d  = 1'b0;
               frozen_d = 1'b1;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pos1_q   <= POS_ZERO;
         pos2_q   <= POS_ZERO;
         y_q      <= 8'd0;
         jc_q     <= CNT_ZERO;
         score_q  <= 16'd0;
         lfsr_q   <= LFSR_SEED;
         duck_q   <= 1'b0;
         crash_q  <= 1'b0;
         frozen_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         pos1_q   <= pos1_d;
         pos2_q   <= pos2_d;
         y_q      <= y_d;
         jc_q     <= jc_d;
         score_q  <= score_d;
         lfsr_q   <= lfsr_d;
         duck_q   <= duck_d;
         crash_q  <= crash_d;
         frozen_q <= frozen_d;
      end
   end

   assign obstacle1_pos  = pos1_q;
   assign obstacle2_pos  = pos2_q;
   assign player_y       = y_q;
   assign player_ducking = duck_q;
   assign crash          = crash_q;
   assign game_frozen    = frozen_q;
   assign score          = score_q;

endmodule
